// File: rtl/spi_slave_rx.sv
// ============================================================================
// spi_slave_rx
//   SPI responder for an 8-bit master. sclk, ss_n and mosi are brought into
//   the clk_out1 domain through synchronizer chains and sclk edges are
//   detected there. Frames are LSB first and sclk idles low: mosi is sampled
//   on sclk fall and miso advances on sclk rise. The preloaded transmit byte
//   is returned on miso; each complete received byte is presented on rx_data
//   with a one-cycle rx_valid pulse.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_out1,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_empty,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_sh;
  logic [SYNC_STAGES-1:0] ss_sh;
  logic [SYNC_STAGES-1:0] mosi_sh;
  // Marks when every synchronizer stage holds a real sample (not a reset value)
  logic [SYNC_STAGES-1:0] primed;
  logic                   sclk_prev;

  logic sclk_sync;
  logic ss_sync;
  logic mosi_sync;
  logic sclk_rise;
  logic sclk_fall;
  logic sync_ready;

  // Set once ss_n has been observed high in IDLE; a frame may only start
  // after that, so a reset in the middle of a frame ignores its remainder.
  logic armed;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_buf;
  logic [WIDTH-1:0] shreg_tx;
  logic [WIDTH-1:0] rx_shreg;

  assign sclk_sync  = sclk_sh[SYNC_STAGES-1];
  assign ss_sync    = ss_sh[SYNC_STAGES-1];
  assign mosi_sync  = mosi_sh[SYNC_STAGES-1];
  assign sync_ready = primed[SYNC_STAGES-1];
  assign sclk_rise  = sclk_sync & ~sclk_prev;
  assign sclk_fall  = ~sclk_sync & sclk_prev;
  assign busy       = (state != S_IDLE);

  // Synchronizer chains for the SPI pins plus the sclk history used for edge detection
  always_ff @(posedge clk_out1) begin
    if (!rst) begin
      sclk_sh   <= '0;
      ss_sh     <= '1;
      mosi_sh   <= '0;
      primed    <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sh   <= {sclk_sh[SYNC_STAGES-2:0], sclk};
      ss_sh     <= {ss_sh[SYNC_STAGES-2:0], ss_n};
      mosi_sh   <= {mosi_sh[SYNC_STAGES-2:0], mosi};
      primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_sync;
    end
  end

  // Frame FSM: loads the tx shifter, shifts bits on sclk edges, reports results
  always_ff @(posedge clk_out1) begin
    if (!rst) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      cnt       <= '0;
      tx_buf    <= '0;
      tx_empty  <= 1'b1;
      shreg_tx  <= '0;
      rx_shreg  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (sync_ready) begin
            if (ss_sync) begin
              armed <= 1'b1;
            end else if (armed) begin
              armed <= 1'b0;
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (ss_sync) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
          end else begin
            shreg_tx <= tx_buf;
            miso     <= tx_buf[0];
            miso_oe  <= 1'b1;
            cnt      <= '0;
            tx_empty <= 1'b1;
            state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (ss_sync) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
          end else if (sclk_fall) begin
            rx_shreg[cnt] <= mosi_sync;
            cnt           <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              state <= S_DONE;
            end
          end else if (sclk_rise && (cnt != '0)) begin
            // Bit 0 was already presented in LOAD; the first rise leaves it
            miso <= shreg_tx[cnt];
          end
        end

        S_DONE: begin
          rx_data  <= rx_shreg;
          rx_valid <= 1'b1;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (ss_sync) begin
            state   <= S_IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // A load always targets the buffer for the next frame and wins over
      // the empty flag being set by LOAD in the same cycle.
      if (tx_load) begin
        tx_buf   <= tx_data;
        tx_empty <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
// ============================================================================
// tb_spi_slave_rx
//   Directed bench for spi_slave_rx: a table of full frames followed by
//   hand-written sequences for abort, mid-frame reset, mid-frame tx_load and
//   over-long frames. sclk runs at clk_out1/8.
//   Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_rx;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sclk = 1'b0;
  logic         ss_n = 1'b1;
  logic         mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_load = 1'b0;
  logic         miso;
  logic         miso_oe;
  logic         tx_empty;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;

  spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_out1  (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_empty  (tx_empty),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_err = 0;
  int valid_cyc = 0;
  int fall_cyc = 0;

  // Pulse monitor sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      valid_cyc = cyc;
    end
    if (frame_err) n_err++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  task automatic select_slave();
    ss_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic deselect_slave();
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(8);
  endtask

  // n sclk pulses; mosi driven on rise, miso captured just before fall
  task automatic sclk_pulses(input logic [W-1:0] mo, input int n, input int load_at,
                             input logic [W-1:0] ld_val, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      mosi = mo[i % W];
      if (i == load_at) begin
        tx_data = ld_val;
        tx_load = 1'b1;
      end
      wait_clk(1);
      tx_load = 1'b0;
      wait_clk(3);
      if (i < W) mi[i] = miso;
      sclk = 1'b0;
      if (i == W - 1) fall_cyc = cyc;
      wait_clk(4);
    end
  endtask

  typedef struct {
    logic         ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] mo;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_mi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [W-1:0] mi;
    int v0;
    int e0;

    vecs[0] = '{ld: 1'b1, ld_val: 8'hA5, mo: 8'h3C, exp_rx: 8'h3C, exp_mi: 8'hA5};
    vecs[1] = '{ld: 1'b0, ld_val: 8'h00, mo: 8'h01, exp_rx: 8'h01, exp_mi: 8'hA5};
    vecs[2] = '{ld: 1'b0, ld_val: 8'h00, mo: 8'h80, exp_rx: 8'h80, exp_mi: 8'hA5};
    vecs[3] = '{ld: 1'b1, ld_val: 8'h00, mo: 8'hFF, exp_rx: 8'hFF, exp_mi: 8'h00};
    vecs[4] = '{ld: 1'b1, ld_val: 8'h96, mo: 8'h69, exp_rx: 8'h69, exp_mi: 8'h96};

    // Reset state
    wait_clk(3);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_miso_oe", 32'(miso_oe), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_tx_empty", 32'(tx_empty), 1);
    rst = 1'b1;
    wait_clk(5);

    // Table of complete frames
    for (int k = 0; k < 5; k++) begin
      if (vecs[k].ld) begin
        do_load(vecs[k].ld_val);
        chk($sformatf("v%0d_tx_empty_loaded", k), 32'(tx_empty), 0);
      end
      v0 = n_valid;
      select_slave();
      chk($sformatf("v%0d_miso_oe", k), 32'(miso_oe), 1);
      chk($sformatf("v%0d_busy", k), 32'(busy), 1);
      sclk_pulses(vecs[k].mo, W, -1, 8'h00, mi);
      wait_clk(4);
      chk($sformatf("v%0d_valid_count", k), 32'(n_valid - v0), 1);
      chk($sformatf("v%0d_rx_data", k), 32'(rx_data), 32'(vecs[k].exp_rx));
      chk($sformatf("v%0d_miso_byte", k), 32'(mi), 32'(vecs[k].exp_mi));
      chk($sformatf("v%0d_latency", k), 32'(valid_cyc - fall_cyc), SS + 2);
      chk($sformatf("v%0d_tx_empty", k), 32'(tx_empty), 1);
      deselect_slave();
      chk($sformatf("v%0d_idle_miso_oe", k), 32'(miso_oe), 0);
      chk($sformatf("v%0d_idle_miso", k), 32'(miso), 0);
      chk($sformatf("v%0d_idle_busy", k), 32'(busy), 0);
    end

    // Abort after 4 falls
    v0 = n_valid;
    e0 = n_err;
    select_slave();
    sclk_pulses(8'hF0, 4, -1, 8'h00, mi);
    ss_n = 1'b1;
    wait_clk(SS + 2);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_miso_oe", 32'(miso_oe), 0);
    wait_clk(8);
    chk("abort_frame_err_pulses", 32'(n_err - e0), 1);
    chk("abort_no_valid", 32'(n_valid - v0), 0);
    chk("abort_rx_data_kept", 32'(rx_data), 32'h69);

    // Reset at bit 5, remainder of frame ignored
    v0 = n_valid;
    e0 = n_err;
    select_slave();
    sclk_pulses(8'hAA, 5, -1, 8'h00, mi);
    rst = 1'b0;
    wait_clk(1);
    chk("mrst_miso", 32'(miso), 0);
    chk("mrst_miso_oe", 32'(miso_oe), 0);
    chk("mrst_rx_data", 32'(rx_data), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_tx_empty", 32'(tx_empty), 1);
    rst = 1'b1;
    sclk_pulses(8'hAA, 3, -1, 8'h00, mi);
    wait_clk(4);
    chk("mrst_ignored_busy", 32'(busy), 0);
    chk("mrst_ignored_valid", 32'(n_valid - v0), 0);
    chk("mrst_no_frame_err", 32'(n_err - e0), 0);
    ss_n = 1'b1;
    wait_clk(8);
    select_slave();
    sclk_pulses(8'hFF, W, -1, 8'h00, mi);
    wait_clk(4);
    chk("mrst_next_valid", 32'(n_valid - v0), 1);
    chk("mrst_next_rx", 32'(rx_data), 32'hFF);
    chk("mrst_next_miso", 32'(mi), 0);
    deselect_slave();

    // tx_load during SHIFT only affects the following frame
    do_load(8'hC3);
    select_slave();
    sclk_pulses(8'h5C, W, 3, 8'h5A, mi);
    wait_clk(4);
    chk("midload_cur_miso", 32'(mi), 32'hC3);
    chk("midload_rx", 32'(rx_data), 32'h5C);
    chk("midload_tx_empty", 32'(tx_empty), 0);
    deselect_slave();
    select_slave();
    sclk_pulses(8'h11, W, -1, 8'h00, mi);
    wait_clk(4);
    chk("midload_next_miso", 32'(mi), 32'h5A);
    chk("midload_next_tx_empty", 32'(tx_empty), 1);
    deselect_slave();

    // 12 sclk pulses in one selection
    v0 = n_valid;
    select_slave();
    sclk_pulses(8'hB7, 12, -1, 8'h00, mi);
    wait_clk(4);
    chk("long_valid_count", 32'(n_valid - v0), 1);
    chk("long_rx", 32'(rx_data), 32'hB7);
    chk("long_miso", 32'(mi), 32'h5A);
    chk("long_miso_oe", 32'(miso_oe), 1);
    chk("long_busy", 32'(busy), 1);
    deselect_slave();
    chk("long_miso_oe_off", 32'(miso_oe), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
